// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first, mid-bit sampling, 1-cycle valid / framing_error strobes.
// Define UART_RX_PARITY_EN for 8E1 framing with an extra parity_error strobe.
module uart_rx #(
  parameter int BAUD_COUNT = 9600,
  parameter int HALF_COUNT = BAUD_COUNT / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       busy,
  output logic       framing_error
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_error
`endif
);

  localparam logic [15:0] BAUD_END = 16'(BAUD_COUNT);
  localparam logic [15:0] HALF_END = 16'(HALF_COUNT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  // Even parity check over the eight data bits plus the received parity bit.
  function automatic logic f_parity_bad(input logic [7:0] d, input logic p);
    f_parity_bad = ^{d, p};
  endfunction

  state_t      r_state;
  logic        r_rx_meta;
  logic        r_rx_s;
  logic [15:0] r_baud_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_busy;
  logic        r_framing_error;
  logic        r_parity_bit;
  logic        r_parity_error;
  logic        w_baud_done;

  assign w_baud_done = (r_baud_cnt == BAUD_END);

  // Two-flop synchroniser for the asynchronous serial line, idling high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Receive FSM: start validation, data shift, optional parity, stop decision, break wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_baud_cnt      <= 16'd0;
      r_bit_idx       <= 3'd0;
      r_shift         <= 8'h00;
      r_data          <= 8'h00;
      r_valid         <= 1'b0;
      r_busy          <= 1'b0;
      r_framing_error <= 1'b0;
      r_parity_bit    <= 1'b0;
      r_parity_error  <= 1'b0;
    end else begin
      r_valid         <= 1'b0;
      r_framing_error <= 1'b0;
      r_parity_error  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_baud_cnt <= 16'd0;
          if (r_rx_s == 1'b0) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_START: begin
          if (r_baud_cnt == HALF_END) begin
            r_baud_cnt <= 16'd0;
            r_bit_idx  <= 3'd0;
            if (r_rx_s == 1'b0) begin
              r_state <= S_DATA;
            end else begin
              // Start bit did not hold to mid-bit: treat as line noise.
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (w_baud_done) begin
            r_baud_cnt <= 16'd0;
            r_shift    <= {r_rx_s, r_shift[7:1]};
            r_bit_idx  <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_state <= S_DATA;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_baud_done) begin
            r_baud_cnt   <= 16'd0;
            r_parity_bit <= r_rx_s;
            r_state      <= S_STOP;
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (w_baud_done) begin
            r_baud_cnt <= 16'd0;
            if (r_rx_s == 1'b1) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
              r_parity_error <= f_parity_bad(r_shift, r_parity_bit);
`endif
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_framing_error <= 1'b1;
              r_state         <= S_BREAK;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
        S_BREAK: begin
          // A held-low line must return high before a new start edge counts.
          if (r_rx_s == 1'b1) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_BREAK;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_baud_cnt <= 16'd0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign data          = r_data;
  assign valid         = r_valid;
  assign busy          = r_busy;
  assign framing_error = r_framing_error;
`ifdef UART_RX_PARITY_EN
  assign parity_error  = r_parity_error;
`else
  logic w_unused;
  assign w_unused = r_parity_bit ^ r_parity_error ^ f_parity_bad(r_shift, r_parity_bit);
`endif

endmodule
